// File: rtl/duty_cmd_ramp.sv
// ============================================================================
// Module   : duty_cmd_ramp
// Brief    : Switch synchroniser, duty-to-on-time conversion and slew-limited
//            on-time command for the dpwm stage. Optional switch debounce is
//            built when DUTY_CMD_DEBOUNCE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module duty_cmd_ramp #(
    parameter int PERIOD  = 1000,
    parameter int TON_MAX = 960,
    parameter int STEP    = 4
`ifdef DUTY_CMD_DEBOUNCE_EN
    ,
    parameter int STABLE_N = 3
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  d_sw,
    input  logic [3:0]  dt1_sw,
    input  logic [3:0]  dt2_sw,
    input  logic        i_ts_last,
    output logic [10:0] o_ton,
    output logic [3:0]  o_dt1,
    output logic [3:0]  o_dt2,
    output logic        o_en,
    output logic        o_at_target
);

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_RAMP = 2'd1;
    localparam logic [1:0]  S_RUN  = 2'd2;
    localparam logic [1:0]  S_STOP = 2'd3;

    localparam logic [18:0] PERIOD_19 = 19'(PERIOD);
    localparam logic [10:0] PMAX      = 11'(PERIOD - 1);
    localparam logic [10:0] TMAX      = 11'(TON_MAX);
    localparam logic [10:0] STEP_11   = 11'(STEP);

    logic        en_m_q,  en_s_q;
    logic [7:0]  d_m_q,   d_s_q;
    logic [3:0]  dt1_m_q, dt1_s_q;
    logic [3:0]  dt2_m_q, dt2_s_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            en_m_q  <= 1'b0;
            en_s_q  <= 1'b0;
            d_m_q   <= '0;
            d_s_q   <= '0;
            dt1_m_q <= '0;
            dt1_s_q <= '0;
            dt2_m_q <= '0;
            dt2_s_q <= '0;
        end else begin
            en_m_q  <= enable;
            en_s_q  <= en_m_q;
            d_m_q   <= d_sw;
            d_s_q   <= d_m_q;
            dt1_m_q <= dt1_sw;
            dt1_s_q <= dt1_m_q;
            dt2_m_q <= dt2_sw;
            dt2_s_q <= dt2_m_q;
        end
    end

    logic [7:0] d_acc;
    logic [3:0] dt1_acc;
    logic [3:0] dt2_acc;

`ifdef DUTY_CMD_DEBOUNCE_EN
    localparam int CW = $clog2(STABLE_N + 1);

    logic [15:0]   bus_s;
    logic [15:0]   samp_q;
    logic [15:0]   acc_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign bus_s = {d_s_q, dt1_s_q, dt2_s_q};

    // Any change between period samples restarts the stability count.
    always_comb begin
        cnt_d = cnt_q;
        if (bus_s != samp_q)
            cnt_d = CW'(1);
        else if (cnt_q != CW'(STABLE_N))
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (i_ts_last) begin
            samp_q <= bus_s;
            cnt_q  <= cnt_d;
            if (cnt_d == CW'(STABLE_N))
                acc_q <= bus_s;
        end
    end

    assign {d_acc, dt1_acc, dt2_acc} = acc_q;
`else
    assign d_acc   = d_s_q;
    assign dt1_acc = dt1_s_q;
    assign dt2_acc = dt2_s_q;
`endif

    logic [18:0] prod;
    logic [10:0] raw;
    logic [10:0] dt_lim;
    logic [10:0] clamp_lim;
    logic [10:0] tgt;

    assign prod      = {11'd0, d_acc} * PERIOD_19;
    assign raw       = 11'(prod >> 8);
    assign dt_lim    = PMAX - {7'd0, dt1_acc} - {7'd0, dt2_acc};
    assign clamp_lim = (dt_lim < TMAX) ? dt_lim : TMAX;
    assign tgt       = (raw < clamp_lim) ? raw : clamp_lim;

    logic [1:0]  state_q, state_d;
    logic [10:0] ton_q,   ton_d;
    logic [3:0]  dt1_q,   dt2_q;
    logic [10:0] toward;
    logic [10:0] down;

    always_comb begin
        toward = tgt;
        if (tgt > ton_q) begin
            if ((tgt - ton_q) > STEP_11)
                toward = ton_q + STEP_11;
        end else if ((ton_q - tgt) > STEP_11) begin
            toward = ton_q - STEP_11;
        end
        down = (ton_q > STEP_11) ? (ton_q - STEP_11) : 11'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ton_q   <= '0;
            dt1_q   <= 4'hF;
            dt2_q   <= 4'hF;
        end else begin
            state_q <= state_d;
            ton_q   <= ton_d;
            if (i_ts_last) begin
                dt1_q <= dt1_acc;
                dt2_q <= dt2_acc;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (en_s_q) state_d = S_RAMP;
            S_RAMP: begin
                if (i_ts_last) begin
                    if (!en_s_q)           state_d = S_STOP;
                    else if (toward == tgt) state_d = S_RUN;
                end
            end
            S_RUN:  if (i_ts_last && !en_s_q) state_d = S_STOP;
            S_STOP: begin
                if (i_ts_last) begin
                    if (en_s_q)            state_d = S_RAMP;
                    else if (down == 11'd0) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A dead-time increase that pulls the clamp below o_ton wins over STEP.
    always_comb begin
        ton_d = ton_q;
        if (state_q == S_IDLE) begin
            ton_d = 11'd0;
        end else if (i_ts_last) begin
            case (state_q)
                S_RAMP, S_RUN: if (en_s_q)  ton_d = toward;
                S_STOP:        if (!en_s_q) ton_d = down;
                default:       ton_d = ton_q;
            endcase
            if (ton_d > clamp_lim)
                ton_d = clamp_lim;
        end
    end

    always_comb begin
        o_en        = (state_q != S_IDLE);
        o_at_target = (state_q == S_RUN) && (ton_q == tgt);
    end

    assign o_ton = ton_q;
    assign o_dt1 = dt1_q;
    assign o_dt2 = dt2_q;

endmodule

`default_nettype wire

// File: tb/tb_duty_cmd_ramp.sv
// ============================================================================
// Module   : tb_duty_cmd_ramp
// Brief    : Directed bench for duty_cmd_ramp (default build, DUTY_CMD_DEBOUNCE_EN
//            undefined); a second instance uses TON_MAX=990.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_duty_cmd_ramp;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  d;
    logic [3:0]  dt1, dt2;
    logic        ts;

    logic [10:0] a_ton, b_ton;
    logic [3:0]  a_dt1, a_dt2, b_dt1, b_dt2;
    logic        a_en, b_en, a_at, b_at;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    duty_cmd_ramp u_a (
        .clk(clk), .rst(rst), .enable(enable), .d_sw(d), .dt1_sw(dt1), .dt2_sw(dt2),
        .i_ts_last(ts), .o_ton(a_ton), .o_dt1(a_dt1), .o_dt2(a_dt2), .o_en(a_en),
        .o_at_target(a_at)
    );

    duty_cmd_ramp #(.TON_MAX(990)) u_b (
        .clk(clk), .rst(rst), .enable(enable), .d_sw(d), .dt1_sw(dt1), .dt2_sw(dt2),
        .i_ts_last(ts), .o_ton(b_ton), .o_dt1(b_dt1), .o_dt2(b_dt2), .o_en(b_en),
        .o_at_target(b_at)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        step_clk(4);
        ts = 1'b1;
        step_clk(1);
        ts = 1'b0;
    endtask

    initial begin
        // T1: reset dominates every input, including i_ts_last
        rst = 1'b1; enable = 1'b1; d = 8'd255; dt1 = 4'd0; dt2 = 4'd0; ts = 1'b1;
        step_clk(3);
        chk("t1_ton",  a_ton, 0);
        chk("t1_dt1",  a_dt1, 15);
        chk("t1_dt2",  a_dt2, 15);
        chk("t1_en",   a_en,  0);
        chk("t1_at",   a_at,  0);
        chk("t1_b_en", b_en,  0);

        enable = 1'b0; ts = 1'b0; d = 8'd128; dt1 = 4'd2; dt2 = 4'd2;
        step_clk(1);
        rst = 1'b0;
        step_clk(5);
        chk("idle_en",  a_en,  0);
        chk("idle_dt1", a_dt1, 15);
        pulse();
        chk("dt_load1", a_dt1, 2);
        chk("dt_load2", a_dt2, 2);
        chk("idle_ton", a_ton, 0);
        chk("idle_en2", a_en,  0);

        // enable passes two sync flops, then IDLE exits on the next edge
        enable = 1'b1;
        step_clk(2);
        chk("en_lat2", a_en, 0);
        step_clk(1);
        chk("en_lat3", a_en, 1);
        chk("en_at0",  a_at, 0);

        // T2: soft-start to 500
        for (int k = 1; k <= 125; k++) begin
            pulse();
            chk("t2_ramp", a_ton, 4 * k);
            if (k == 124) chk("t2_at_pre", a_at, 0);
        end
        chk("t2_at",    a_at,  1);
        chk("t2_en",    a_en,  1);
        chk("t2_b_ton", b_ton, 500);

        // T3: clamp; A limited by TON_MAX, B by dead-time
        d = 8'd255; dt1 = 4'd15; dt2 = 4'd15;
        for (int k = 1; k <= 118; k++) begin
            pulse();
            if (k == 1)   chk("t3_first", a_ton, 504);
            if (k == 115) chk("t3_a115",  a_ton, 960);
            if (k == 117) chk("t3_b117",  b_ton, 968);
        end
        chk("t3_a_ton", a_ton, 960);
        chk("t3_b_ton", b_ton, 969);
        chk("t3_a_at",  a_at,  1);
        chk("t3_b_at",  b_at,  1);
        chk("t3_dt1",   a_dt1, 15);

        // T6: dead-time raise forces o_ton down to the new clamp
        dt1 = 4'd0; dt2 = 4'd0;
        for (int k = 1; k <= 6; k++) pulse();
        chk("t6_b_990", b_ton, 990);
        chk("t6_a_960", a_ton, 960);
        chk("t6_dt0",   a_dt1, 0);
        dt1 = 4'd15; dt2 = 4'd15;
        pulse();
        chk("t6_a_dt1", a_dt1, 15);
        chk("t6_b_dt2", b_dt2, 15);
        chk("t6_a_ton", a_ton, 960);
        chk("t6_b_ton", b_ton, 969);
        chk("t6_b_at",  b_at,  1);

        // T4: back to 500, then soft-stop and re-enable mid-stop
        d = 8'd128; dt1 = 4'd2; dt2 = 4'd2;
        for (int k = 1; k <= 118; k++) pulse();
        chk("t4_a_500", a_ton, 500);
        chk("t4_b_500", b_ton, 500);
        chk("t4_at",    a_at,  1);
        enable = 1'b0;
        step_clk(3);
        pulse();
        chk("t4_nostep", a_ton, 500);
        chk("t4_en",     a_en,  1);
        chk("t4_at0",    a_at,  0);
        for (int k = 1; k <= 75; k++) pulse();
        chk("t4_a_200", a_ton, 200);
        chk("t4_b_200", b_ton, 200);
        enable = 1'b1;
        step_clk(3);
        pulse();
        chk("t4_re_hold", a_ton, 200);
        chk("t4_re_en",   a_en,  1);
        pulse();
        chk("t4_re_up",   a_ton, 204);
        enable = 1'b0;
        step_clk(3);
        pulse();
        chk("t4_stop2", a_ton, 204);
        for (int k = 1; k <= 50; k++) pulse();
        chk("t4_ton4",  a_ton, 4);
        chk("t4_en4",   a_en,  1);
        pulse();
        chk("t4_ton0",  a_ton, 0);
        chk("t4_en0",   a_en,  0);
        chk("t4_b_en0", b_en,  0);
        pulse();
        chk("t4_idle_ton", a_ton, 0);
        chk("t4_idle_en",  a_en,  0);

        // d_sw = 0: enabled, RUN at zero on-time
        d = 8'd0;
        enable = 1'b1;
        step_clk(4);
        chk("d0_en", a_en, 1);
        pulse();
        chk("d0_ton", a_ton, 0);
        chk("d0_at",  a_at,  1);

        // reset in the middle of a ramp
        d = 8'd128;
        step_clk(3);
        for (int k = 1; k <= 3; k++) pulse();
        chk("mr_ton12", a_ton, 12);
        rst = 1'b1;
        step_clk(1);
        chk("mr_ton", a_ton, 0);
        chk("mr_en",  a_en,  0);
        chk("mr_dt1", a_dt1, 15);
        chk("mr_at",  a_at,  0);
        rst = 1'b0;
        step_clk(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
